// File: rtl/vscale_timer.sv
// vscale_timer: HASTI slave timer with prescaler, compare match and irq.
// Zero-wait-state bus; registers decoded from addr[4:2].
module vscale_timer #(
   parameter int ADDR_WIDTH = 32,
   parameter int BUS_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sel,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  read,
   input  logic                  write,
   input  logic [2:0]            size,
   input  logic [BUS_WIDTH-1:0]  wdata,
   output logic [BUS_WIDTH-1:0]  rdata,
   output logic                  ready,
   output logic                  resp,
   output logic                  irq
);

   localparam logic [2:0] A_CTRL     = 3'd0;
   localparam logic [2:0] A_PRESCALE = 3'd1;
   localparam logic [2:0] A_COMPARE  = 3'd2;
   localparam logic [2:0] A_COUNT    = 3'd3;
   localparam logic [2:0] A_STATUS   = 3'd4;

   // registered address phase
   logic        dp_wr;
   logic        dp_rd;
   logic [2:0]  dp_addr;

   // architectural state
   logic [2:0]  ctrl;
   logic [15:0] prescale;
   logic [31:0] compare;
   logic [31:0] count;
   logic        match;
   logic [15:0] pcnt;

   // next-state values
   logic [15:0] pcnt_next;
   logic [31:0] count_next;
   logic        match_next;

   // decoded write strobes for the current data phase
   logic        wr_ctrl;
   logic        wr_prescale;
   logic        wr_compare;
   logic        wr_count;
   logic        wr_status;

   logic        en;
   logic        irq_en;
   logic        auto_reload;
   logic        tick;
   logic        hit;
   logic [31:0] wword;
   logic [31:0] rword;

   // size, high/low address bits and upper data bits carry no meaning here
   logic        unused_bits;
   assign unused_bits = ^{size, addr, wdata};

   assign wword       = wdata[31:0];
   assign en          = ctrl[0];
   assign irq_en      = ctrl[1];
   assign auto_reload = ctrl[2];

   assign tick = en && (pcnt == prescale);
   assign hit  = tick && (count == compare);

   assign ready = 1'b1;
   assign resp  = 1'b0;
   assign irq   = match & irq_en;

   // capture address phase; read+write together is a write
   always_ff @(posedge clk) begin
      if (reset) begin
         dp_wr   <= 1'b0;
         dp_rd   <= 1'b0;
         dp_addr <= 3'd0;
      end else begin
         dp_wr   <= sel & write;
         dp_rd   <= sel & read & ~write;
         dp_addr <= (sel & (read | write)) ? addr[4:2] : 3'd0;
      end
   end

   // one-hot write strobes from the registered address
   always_comb begin
      wr_ctrl     = 1'b0;
      wr_prescale = 1'b0;
      wr_compare  = 1'b0;
      wr_count    = 1'b0;
      wr_status   = 1'b0;
      if (dp_wr) begin
         unique case (1'b1)
            (dp_addr == A_CTRL):     wr_ctrl     = 1'b1;
            (dp_addr == A_PRESCALE): wr_prescale = 1'b1;
            (dp_addr == A_COMPARE):  wr_compare  = 1'b1;
            (dp_addr == A_COUNT):    wr_count    = 1'b1;
            (dp_addr == A_STATUS):   wr_status   = 1'b1;
            default: ;
         endcase
      end
   end

   // prescaler: restarts on config writes, idles at 0 when disabled
   always_comb begin
      pcnt_next = pcnt + 16'd1;
      if (wr_ctrl || wr_prescale || !en || tick)
         pcnt_next = 16'd0;
   end

   // counter: bus write beats the tick; match uses pre-write count
   always_comb begin
      count_next = count;
      if (wr_count)
         count_next = wword;
      else if (tick)
         count_next = (hit && auto_reload) ? 32'd0 : count + 32'd1;
   end

   // match flag: a new hit beats a simultaneous W1C
   always_comb begin
      match_next = match;
      if (hit)
         match_next = 1'b1;
      else if (wr_status && wword[0])
         match_next = 1'b0;
   end

   // register file and counter state
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl     <= 3'd0;
         prescale <= 16'd0;
         compare  <= 32'd0;
         count    <= 32'd0;
         match    <= 1'b0;
         pcnt     <= 16'd0;
      end else begin
         if (wr_ctrl)
            ctrl <= wword[2:0];
         if (wr_prescale)
            prescale <= wword[15:0];
         if (wr_compare)
            compare <= wword;
         count <= count_next;
         match <= match_next;
         pcnt  <= pcnt_next;
      end
   end

   // read mux; zero outside a read data phase
   always_comb begin
      rword = 32'd0;
      if (dp_rd) begin
         case (dp_addr)
            A_CTRL:     rword = {29'd0, ctrl};
            A_PRESCALE: rword = {16'd0, prescale};
            A_COMPARE:  rword = compare;
            A_COUNT:    rword = count;
            A_STATUS:   rword = {31'd0, match};
            default:    rword = 32'd0;
         endcase
      end
   end

   assign rdata = rword;

endmodule

// File: doc/vscale_timer.md
VSCALE_TIMER -- requirements
Module: vscale_timer

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, HASTI address width.
REQ-002 Parameter: BUS_WIDTH, default 32, HASTI data width; only 32 is supported.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: sel  input  1  slave select from crossbar slave port.
REQ-006 Port: addr  input  ADDR_WIDTH  byte address, address phase; only addr[4:2] decoded.
REQ-007 Port: read  input  1  read request, address phase.
REQ-008 Port: write  input  1  write request, address phase.
REQ-009 Port: size  input  3  transfer size; ignored, all accesses treated as 32-bit.
REQ-010 Port: wdata  input  BUS_WIDTH  write data, data phase.
REQ-011 Port: rdata  output  BUS_WIDTH  read data, data phase.
REQ-012 Port: ready  output  1  transfer ready; constant 1, zero wait states.
REQ-013 Port: resp  output  1  transfer response; constant 0 (OKAY).
REQ-014 Port: irq  output  1  level interrupt to a core ext_interrupts bit.

Function
REQ-015 Register map (offset from addr[4:2]):
- 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD; other bits read 0.
- 0x04 PRESCALE: bits[15:0]; other bits read 0.
- 0x08 COMPARE: 32 bits.
- 0x0C COUNT: 32 bits, read/write.
- 0x10 STATUS: bit0 MATCH; write-1-to-clear.
- 0x14-0x1C: read 0, writes ignored.
REQ-016 Address phase, cycle t: sel&read or sel&write registers addr[4:2] and the access type; read and write both high counts as a write.
REQ-017 Write: wdata sampled in cycle t+1; target register updated at the end of t+1; visible on the next read.
REQ-018 Read: rdata valid in cycle t+1, taken from the register value current in t+1; rdata is 0 in any cycle with no read data phase.
REQ-019 Back-to-back accesses on consecutive cycles are supported: the address phase of access n+1 overlaps the data phase of access n.
REQ-020 Prescaler: 16-bit pcnt.
- EN=1: pcnt increments each cycle.
- When pcnt==PRESCALE: tick=1 for that cycle and pcnt returns to 0. PRESCALE=0 gives a tick every cycle.
REQ-021 EN=0: pcnt held at 0, no ticks, COUNT frozen.
REQ-022 Any write to PRESCALE or to CTRL clears pcnt to 0 in the same update.
REQ-023 On tick:
- COUNT==COMPARE: set MATCH; AUTO_RELOAD=1 loads COUNT with 0; AUTO_RELOAD=0 increments COUNT.
- Otherwise: increment COUNT.
- Increment wraps 0xFFFFFFFF to 0x00000000.
REQ-024 Software write to COUNT in the same cycle as a tick: the written value wins; no increment; match compare uses the pre-write COUNT.
REQ-025 STATUS W1C in the same cycle as a new match: set wins, MATCH stays 1.
REQ-026 irq = MATCH & IRQ_EN, combinational from registers; no glitch path from bus inputs.

Reset
REQ-027 While reset=1 at a clock edge, the following are cleared to 0:
- CTRL, PRESCALE, COMPARE, COUNT, MATCH, pcnt;
- the registered address-phase state, discarding any pending data phase.
REQ-028 Outputs during and after reset: rdata=0, irq=0, ready=1, resp=0.
REQ-029 Reset asserted mid-count or mid-transfer aborts the operation; no register update from the aborted data phase.

Verification
REQ-030 Reset, then read every offset 0x00-0x1C -> all return 0x00000000; ready=1, resp=0 every cycle.
REQ-031 Setup: PRESCALE=3, COMPARE=5, CTRL=0x3.
- COUNT reaches 5 after 20 clocks from the CTRL write.
- MATCH and irq rise on the following tick, 24 clocks after the CTRL write.
- W1C STATUS=1 -> irq drops the cycle after the data phase.
REQ-032 Setup: PRESCALE=0, COMPARE=2, CTRL=0x5 (AUTO_RELOAD) -> COUNT sequence 0,1,2,0,1,2; MATCH=1 with irq=0 because IRQ_EN=0.
REQ-033 Setup: COUNT=0xFFFFFFFE, COMPARE=0x10, PRESCALE=0, EN=1 -> COUNT reads 0xFFFFFFFF, then 0x00000000; no MATCH.
REQ-034 Collision cases:
- Write COUNT=0x100 in a tick cycle -> next read returns 0x100.
- W1C STATUS in a match cycle -> MATCH remains 1.
REQ-035 Back-to-back write COMPARE=0xA then read COMPARE -> read returns 0xA; reset asserted during a pending write data phase -> register stays 0.
